seq_match_ctrl: RTL and testbench
=================================

SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameter WORD_W, default 16: width of each input word, serialized MSB first.
REQ-002 Parameter PAT_W, default 4: detected pattern length in bits; PAT_W SHALL be in 2..WORD_W.
REQ-003 Parameter CNT_W, default $clog2(WORD_W+1): match counter width.
REQ-004 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 cfg_we  in  1  pattern write strobe.
REQ-007 cfg_pattern  in  PAT_W  new pattern; MSB is the first bit of the sequence.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  block accepts a word.
REQ-010 in_data  in  WORD_W  word to scan.
REQ-011 out_valid  out  1  result is valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_count  out  CNT_W  number of matches in the word.
REQ-014 match_pulse  out  1  one-cycle strobe per detected match.
REQ-015 busy  out  1  high in SHIFT and REPORT.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and REPORT.
REQ-017 IDLE: in_ready=1; on in_valid the block SHALL load in_data into the shift register, clear the history, fill counter and match counter, and go to SHIFT.
REQ-018 SHIFT: the block SHALL consume one bit per cycle, MSB first, for exactly WORD_W cycles, then go to REPORT.
REQ-019 Each consumed bit SHALL shift into a PAT_W-bit history; a match occurs when the updated history equals the stored pattern and at least PAT_W bits of the current word have been consumed.
REQ-020 Detection SHALL be overlapping; history SHALL NOT carry across words.
REQ-021 On a match, the match counter SHALL increment on the same edge that consumes the completing bit, and match_pulse SHALL be high for the following cycle.
REQ-022 The counter SHALL NOT need saturation, since the maximum count is WORD_W-PAT_W+1.
REQ-023 REPORT: out_valid=1 with out_count held stable until out_ready=1; on that cycle the block SHALL return to IDLE.
REQ-024 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored.
REQ-025 Latency: a word accepted at edge T SHALL produce out_valid from the cycle after edge T+WORD_W, i.e. 16 bit edges then REPORT for the default.
REQ-026 cfg_we SHALL update the pattern only in IDLE and SHALL be ignored in SHIFT and REPORT.
REQ-027 cfg_we and in_valid on the same IDLE cycle: the new pattern SHALL apply to that word.
REQ-028 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-029 With rst high at an edge, the block SHALL enter IDLE and set out_valid=0, out_count=0, match_pulse=0, busy=0 and in_ready=1 from the next cycle.
REQ-030 Reset SHALL restore the stored pattern to 4'b1010 (the PAT_W LSBs of the repeating 10 pattern).
REQ-031 Reset mid-SHIFT or mid-REPORT SHALL abandon the word with no result and no match_pulse.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default pattern constant and the width defaults.
REQ-033 Sub-module seq_pattern_match SHALL contain the history register, fill counter and compare; seq_match_ctrl SHALL contain the FSM, shift register, bit counter, match counter and handshakes.

Verification
REQ-034 Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, out_count=0, busy=0.
REQ-035 Default pattern 1010, word 16'hAAAA -> 7 match_pulses, out_count=7, out_valid asserted 17 cycles after acceptance.
REQ-036 Word 16'h0000 -> out_count=0, no match_pulse; then pattern 4'b1111 with word 16'hFFFF -> out_count=13.
REQ-037 Backpressure: out_ready low 5 cycles in REPORT -> out_valid and out_count stable, in_ready=0; in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-038 cfg_we with 4'b0000 during SHIFT -> ignored, current and next word still use 1010.
REQ-039 rst asserted after 8 bits of 16'hAAAA -> IDLE next cycle, out_count=0, no out_valid, pattern=1010.

Source files
------------

// File: rtl/seq_match_ctrl_pkg.sv
// Shared definitions for the serial pattern-match controller.
package seq_match_ctrl_pkg;

  localparam int unsigned DEF_WORD_W = 16;
  localparam int unsigned DEF_PAT_W  = 4;

  // Repeating ...1010 fill; the stored pattern resets to its PAT_W LSBs.
  localparam logic [63:0] DEF_PATTERN_FILL = {32{2'b10}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_REPORT = 2'b10
  } state_t;

endpackage

// File: rtl/seq_pattern_match.sv
// Bit-serial pattern detector: PAT_W-bit history, fill counter and compare.
module seq_pattern_match
  import seq_match_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill;

  // Compare the history as it will look after this bit; require a full window.
  always_comb begin
    hist_next = {hist[PAT_W-2:0], bit_in};
    match     = bit_valid && (hist_next == pattern) && (fill >= FILL_W'(PAT_W - 1));
  end

  // History shifts per consumed bit; fill saturates once a full window exists.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= hist_next;
      if (fill != FILL_W'(PAT_W)) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// Word-serial match counter: loads a word, scans it MSB first for a
// programmable pattern (overlapping), then reports the match count.
module seq_match_ctrl
  import seq_match_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned PAT_W  = DEF_PAT_W,
  parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              match_pulse,
  output logic              busy
);

  localparam int unsigned     BC_W     = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bitcnt;
  logic [CNT_W-1:0]  count;
  logic [PAT_W-1:0]  pattern;
  logic              match;
  logic              load;
  logic              shifting;

  assign load      = in_ready && in_valid;
  assign shifting  = (state == ST_SHIFT);
  assign out_count = count;

  // Next-state and handshake outputs; unknown encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (bitcnt == LAST_BIT) begin
          state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pattern store, shift register, bit counter, match counter and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern     <= DEF_PATTERN_FILL[PAT_W-1:0];
      shreg       <= '0;
      bitcnt      <= '0;
      count       <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= shifting && match;
      if ((state == ST_IDLE) && cfg_we) begin
        pattern <= cfg_pattern;
      end
      if (load) begin
        shreg  <= in_data;
        bitcnt <= '0;
        count  <= '0;
      end else if (shifting) begin
        shreg  <= shreg << 1;
        bitcnt <= bitcnt + BC_W'(1);
        if (match) begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  // Pattern write on the load cycle lands before the first bit is compared.
  seq_pattern_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk       (clk),
    .rst       (rst),
    .clear     (load),
    .bit_valid (shifting),
    .bit_in    (shreg[WORD_W-1]),
    .pattern   (pattern),
    .match     (match)
  );

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl with a window-based reference model.
module tb_seq_match_ctrl;

  localparam int WW = 16;
  localparam int PW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_pattern;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          match_pulse;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  seq_match_ctrl #(
    .WORD_W (WW),
    .PAT_W  (PW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .match_pulse (match_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // True when the PW bits ending at consumed bit k (MSB first) equal p.
  function automatic bit window_hit(logic [WW-1:0] w, logic [PW-1:0] p, int k);
    int unsigned win;
    if (k < PW - 1) return 1'b0;
    win = (int'(w) >> (WW - 1 - k)) & ((1 << PW) - 1);
    return win == int'(p);
  endfunction

  function automatic int count_matches(logic [WW-1:0] w, logic [PW-1:0] p);
    int n = 0;
    for (int k = 0; k < WW; k++) n += int'(window_hit(w, p, k));
    return n;
  endfunction

  // Reference model: mode 0 waiting, 1 scanning (k bits consumed), 2 reporting.
  int            m_mode = 0;
  int            m_k    = 0;
  int            m_cnt  = 0;
  bit            m_pulse = 1'b0;
  bit            m_init  = 1'b0;
  logic [WW-1:0] m_word = '0;
  logic [PW-1:0] m_pat  = 4'b1010;

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1'b1;
      m_mode  <= 0;
      m_pat   <= 4'b1010;
      m_cnt   <= 0;
      m_pulse <= 1'b0;
    end else if (m_init) begin
      case (m_mode)
        0: begin
          m_pulse <= 1'b0;
          if (cfg_we) m_pat <= cfg_pattern;
          if (in_valid) begin
            m_word <= in_data;
            m_k    <= 0;
            m_cnt  <= 0;
            m_mode <= 1;
          end
        end
        1: begin
          m_pulse <= window_hit(m_word, m_pat, m_k);
          m_cnt   <= m_cnt + int'(window_hit(m_word, m_pat, m_k));
          m_k     <= m_k + 1;
          if (m_k == WW - 1) m_mode <= 2;
        end
        default: begin
          m_pulse <= 1'b0;
          if (out_ready) m_mode <= 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready",    in_ready,    m_mode == 0);
      chk("busy",        busy,        m_mode != 0);
      chk("out_valid",   out_valid,   m_mode == 2);
      chk("match_pulse", match_pulse, m_pulse);
      if (m_mode == 2) chk("out_count", out_count, m_cnt);
      if (match_pulse) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [WW-1:0] w, bit we, logic [PW-1:0] p);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid    = 1'b1;
    in_data     = w;
    cfg_we      = we;
    cfg_pattern = p;
    pulses      = 0;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  // Waits for the report, stalls, completes the handshake; lat counts cycles
  // from the accepting cycle (cycle 0) to the first out_valid cycle.
  task automatic finish(int stall, output int cnt, output int lat, output int np);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("report_timeout", 0, 1);
    cnt = int'(out_count);
    for (int i = 0; i < stall; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    np = pulses;
  endtask

  initial begin
    int cnt, lat, np;
    logic [WW-1:0] w;
    logic [PW-1:0] p;
    logic [PW-1:0] cur_pat;
    bit we;

    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_busy",      busy,      0);

    // Default 1010 on AAAA.
    send(16'hAAAA, 1'b0, '0);
    finish(0, cnt, lat, np);
    chk("aaaa_count",   cnt, 7);
    chk("aaaa_pulses",  np,  7);
    chk("aaaa_latency", lat, 17);

    send(16'h0000, 1'b0, '0);
    finish(1, cnt, lat, np);
    chk("zero_count",  cnt, 0);
    chk("zero_pulses", np,  0);

    send(16'hFFFF, 1'b1, 4'b1111);
    finish(0, cnt, lat, np);
    chk("ffff_count",  cnt, 13);
    chk("ffff_pulses", np,  13);

    // Backpressure with ignored in_valid pulses.
    send(16'hAAAA, 1'b1, 4'b1010);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 16'hFFFF;
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_count", out_count, 7);
      chk("bp_in_ready",  in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy",     busy,     0);

    // Pattern write during SHIFT is ignored.
    send(16'hAAAA, 1'b0, '0);
    tick();
    tick();
    cfg_we = 1'b1;
    cfg_pattern = 4'b0000;
    tick();
    cfg_we = 1'b0;
    finish(0, cnt, lat, np);
    chk("shift_cfg_count", cnt, 7);
    send(16'hAAAA, 1'b0, '0);
    finish(0, cnt, lat, np);
    chk("shift_cfg_next_count", cnt, 7);

    // Pattern written alongside the word applies to that word.
    send(16'hAAAA, 1'b1, 4'b0101);
    finish(2, cnt, lat, np);
    chk("same_cycle_cfg_count", cnt, 6);

    // Reset after 8 bits abandons the word and restores 1010.
    send(16'hAAAA, 1'b1, 4'b1111);
    for (int i = 0; i < 7; i++) tick();
    pulses = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_count", out_count, 0);
    chk("midrst_busy",      busy,      0);
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_pulses", pulses, 0);
    send(16'hAAAA, 1'b0, '0);
    finish(0, cnt, lat, np);
    chk("midrst_pattern_count", cnt, 7);

    // Randomized words, patterns and stalls.
    cur_pat = 4'b1010;
    for (int i = 0; i < 24; i++) begin
      w  = WW'($urandom);
      p  = PW'($urandom);
      we = 1'($urandom_range(0, 1));
      if (i % 4 == 0) w = {4{p}};
      if (we) cur_pat = p;
      send(w, we, p);
      finish(int'($urandom_range(0, 3)), cnt, lat, np);
      chk("rand_count",   cnt, count_matches(w, cur_pat));
      chk("rand_pulses",  np,  count_matches(w, cur_pat));
      chk("rand_latency", lat, 17);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
